// File: rtl/max7219_pkg.sv
// Shared types and MAX7219 register map for the command arbiter and its helpers.
package max7219_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DIGIT0     = 8'h01;
    localparam logic [ADDR_W-1:0] DIGIT1     = 8'h02;
    localparam logic [ADDR_W-1:0] DIGIT2     = 8'h03;
    localparam logic [ADDR_W-1:0] DIGIT3     = 8'h04;
    localparam logic [ADDR_W-1:0] DIGIT4     = 8'h05;
    localparam logic [ADDR_W-1:0] DIGIT5     = 8'h06;
    localparam logic [ADDR_W-1:0] DIGIT6     = 8'h07;
    localparam logic [ADDR_W-1:0] DIGIT7     = 8'h08;
    localparam logic [ADDR_W-1:0] DECODE     = 8'h09;
    localparam logic [ADDR_W-1:0] INTENSITY  = 8'h0A;
    localparam logic [ADDR_W-1:0] SCAN_LIMIT = 8'h0B;
    localparam logic [ADDR_W-1:0] SHUTDOWN   = 8'h0C;
    localparam logic [ADDR_W-1:0] TEST       = 8'h0F;

endpackage

// File: rtl/max7219_cmd_arbiter_rr_picker.sv
// Combinational round-robin selector: first set bit of valid after index last, with wrap.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0] valid,
    input  logic [2:0]   last,
    output logic         found,
    output logic [2:0]   index
);

    logic [N-1:0] rot;

    always_comb begin
        found = 1'b0;
        index = 3'd0;
        rot   = '0;
        for (int k = 1; k <= N; k++) begin
            rot = valid >> ((int'(last) + k) % N);
            if (!found && rot[0]) begin
                found = 1'b1;
                index = 3'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/max7219_cmd_arbiter.sv
// Round-robin arbiter sharing one MAX7219 serial write engine between NUM_REQ sources.
// Optional phase timeout enabled by defining MAX7219_ARB_TIMEOUT_EN.
module max7219_cmd_arbiter
    import max7219_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*8-1:0]  req_addr,
    input  logic [NUM_REQ*8-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  eng_start,
    output logic [ADDR_W-1:0]     eng_addr,
    output logic [DATA_W-1:0]     eng_data,
    input  logic                  eng_busy,
    output logic                  arb_busy,
    output logic [2:0]            grant_id,
    output logic                  timeout_err,
    output state_t                fsm_state
);

    // Handshake: a request is taken on the edge where req_valid[i] and req_ready[i]
    // are both high; ready is only offered in IDLE with the engine idle and never
    // without the matching valid.

    state_t     state, next_state;
    logic [2:0] last_grant;
    logic [2:0] winner;
    logic       found;
    logic       accept;
    logic       abort;

    rr_picker #(.N(NUM_REQ)) u_picker (
        .valid (req_valid),
        .last  (last_grant),
        .found (found),
        .index (winner)
    );

    assign arb_busy  = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        accept     = (state == IDLE) && !reset && !eng_busy && found;
        req_ready  = '0;
        next_state = state;
        if (accept) req_ready = NUM_REQ'(1) << winner;
        case (state)
            IDLE:      if (accept) next_state = ISSUE;
            ISSUE: begin
                if (abort)         next_state = IDLE;
                else if (eng_busy) next_state = WAIT_DONE;
            end
            WAIT_DONE: if (abort || !eng_busy) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            eng_start  <= 1'b0;
            eng_addr   <= '0;
            eng_data   <= '0;
            grant_id   <= 3'd0;
            last_grant <= 3'(NUM_REQ - 1);
            req_done   <= '0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        eng_addr   <= ADDR_W'(req_addr >> {winner, 3'b000});
                        eng_data   <= DATA_W'(req_data >> {winner, 3'b000});
                        grant_id   <= winner;
                        last_grant <= winner;
                        eng_start  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (abort || eng_busy) eng_start <= 1'b0;
                    if (abort) req_done <= NUM_REQ'(1) << grant_id;
                end
                WAIT_DONE: begin
                    if (abort || !eng_busy) req_done <= NUM_REQ'(1) << grant_id;
                end
                default: eng_start <= 1'b0;
            endcase
        end
    end

`ifdef MAX7219_ARB_TIMEOUT_EN
    logic [15:0] phase_cnt;

    assign abort = (state != IDLE) && (phase_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every entry into a waiting phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (next_state != state && next_state != IDLE) phase_cnt <= '0;
            else if (state != IDLE)                        phase_cnt <= phase_cnt + 16'd1;
            if (abort) timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign abort              = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_cmd_arbiter.sv
// Directed self-checking bench for max7219_cmd_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_max7219_cmd_arbiter;
    import max7219_pkg::*;

    localparam int NR = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*8-1:0] req_addr  = '0;
    logic [NR*8-1:0] req_data  = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_done;
    logic            eng_start;
    logic [7:0]      eng_addr;
    logic [7:0]      eng_data;
    logic            eng_busy = 1'b0;
    logic            arb_busy;
    logic [2:0]      grant_id;
    logic            timeout_err;
    state_t          fsm_state;

    int checks = 0;
    int errors = 0;
    int done_cnt [NR];

    max7219_cmd_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .eng_start   (eng_start),
        .eng_addr    (eng_addr),
        .eng_data    (eng_data),
        .eng_busy    (eng_busy),
        .arb_busy    (arb_busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .fsm_state   (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            req_addr[i*8 +: 8] = DIGIT0 + 8'(i);
            req_data[i*8 +: 8] = 8'h10 * 8'(i) + 8'h05;
            done_cnt[i] = 0;
        end
        tick();
        tick();
        chk("rst_busy",  32'(arb_busy),    32'h0);
        chk("rst_start", 32'(eng_start),   32'h0);
        chk("rst_addr",  32'(eng_addr),    32'h0);
        chk("rst_data",  32'(eng_data),    32'h0);
        chk("rst_gid",   32'(grant_id),    32'h0);
        chk("rst_terr",  32'(timeout_err), 32'h0);
        chk("rst_done",  32'(req_done),    32'h0);
        reset = 1'b0;

        // Single request from requester 2 with a 20-cycle engine busy window
        req_addr[23:16] = SHUTDOWN;
        req_data[23:16] = 8'h01;
        req_valid = 4'b0100;
        #1 chk("s_ready", 32'(req_ready), 32'h4);
        tick();
        chk("s_start", 32'(eng_start), 32'h1);
        chk("s_addr",  32'(eng_addr),  32'h0C);
        chk("s_data",  32'(eng_data),  32'h01);
        chk("s_gid",   32'(grant_id),  32'h2);
        chk("s_state", 32'(fsm_state), 32'(ISSUE));
        req_valid = '0;
        eng_busy  = 1'b1;
        tick();
        chk("s_start_drop", 32'(eng_start), 32'h0);
        for (int c = 0; c < 19; c++) begin
            chk("s_no_done", 32'(req_done), 32'h0);
            tick();
        end
        eng_busy = 1'b0;
        tick();
        chk("s_done",      32'(req_done), 32'h4);
        chk("s_idle",      32'(arb_busy), 32'h0);
        tick();
        chk("s_done_once", 32'(req_done), 32'h0);
        chk("s_addr_hold", 32'(eng_addr), 32'h0C);
        req_addr[23:16] = DIGIT2;
        req_data[23:16] = 8'h25;

        // Fairness: all requesters valid, 8 writes
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk("f_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            chk("f_gid",   32'(grant_id),  32'(k % 4));
            chk("f_start", 32'(eng_start), 32'h1);
            chk("f_addr",  32'(eng_addr),  32'(DIGIT0) + 32'(k % 4));
            eng_busy = 1'b1;
            tick();
            chk("f_start_drop", 32'(eng_start), 32'h0);
            tick();
            tick();
            eng_busy = 1'b0;
            tick();
            chk("f_done", 32'(req_done), 32'(1 << (k % 4)));
            for (int i = 0; i < NR; i++) done_cnt[i] += int'(req_done[i]);
        end
        for (int i = 0; i < NR; i++) chk("f_done_cnt", 32'(done_cnt[i]), 32'd2);
        req_valid = '0;
        tick();

        // Engine already busy at reset release
        reset    = 1'b1;
        eng_busy = 1'b1;
        req_valid = 4'b0001;
        tick();
        reset = 1'b0;
        #1 chk("b_no_ready0", 32'(req_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("b_no_ready", 32'(req_ready), 32'h0);
            chk("b_idle",     32'(arb_busy),  32'h0);
        end
        eng_busy = 1'b0;
        #1 chk("b_ready", 32'(req_ready), 32'h1);
        tick();
        chk("b_gid", 32'(grant_id), 32'h0);
        req_valid = '0;
        eng_busy  = 1'b1;
        tick();
        eng_busy = 1'b0;
        tick();
        chk("b_done", 32'(req_done), 32'h1);

        // Withdrawal of requester 1 while in WAIT_DONE
        req_valid = 4'b0100;
        #1 chk("w_ready2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        eng_busy  = 1'b1;
        tick();
        chk("w_state", 32'(fsm_state), 32'(WAIT_DONE));
        req_valid = 4'b0010;
        #1 chk("w_no_ready1", 32'(req_ready), 32'h0);
        tick();
        req_valid = 4'b1000;
        eng_busy  = 1'b0;
        tick();
        chk("w_done2", 32'(req_done), 32'h4);
        #1 chk("w_ready3", 32'(req_ready), 32'h8);
        tick();
        chk("w_gid3", 32'(grant_id), 32'h3);
        req_valid = '0;
        eng_busy  = 1'b1;
        tick();
        eng_busy = 1'b0;
        tick();
        chk("w_done3", 32'(req_done), 32'h8);

        // Reset in the middle of a transfer
        req_valid = 4'b0010;
        tick();
        chk("r_gid1", 32'(grant_id), 32'h1);
        req_valid = '0;
        eng_busy  = 1'b1;
        tick();
        chk("r_state", 32'(fsm_state), 32'(WAIT_DONE));
        reset = 1'b1;
        tick();
        chk("r_idle",  32'(arb_busy),  32'h0);
        chk("r_start", 32'(eng_start), 32'h0);
        chk("r_done",  32'(req_done),  32'h0);
        reset    = 1'b0;
        eng_busy = 1'b0;
        tick();
        chk("r_no_done", 32'(req_done), 32'h0);
        req_valid = 4'b1001;
        #1 chk("r_ready0", 32'(req_ready), 32'h1);
        tick();
        chk("r_gid0", 32'(grant_id), 32'h0);
        req_valid = '0;
        eng_busy  = 1'b1;
        tick();
        eng_busy = 1'b0;
        tick();
        chk("r_done0", 32'(req_done), 32'h1);
        tick();

`ifdef MAX7219_ARB_TIMEOUT_EN
        // Engine never answers: abort after 16 ISSUE cycles
        do_reset();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("t_start", 32'(eng_start), 32'h1);
        for (int c = 0; c < 15; c++) begin
            tick();
            chk("t_wait_start", 32'(eng_start),   32'h1);
            chk("t_wait_err",   32'(timeout_err), 32'h0);
        end
        tick();
        chk("t_start_drop", 32'(eng_start),   32'h0);
        chk("t_err",        32'(timeout_err), 32'h1);
        chk("t_done",       32'(req_done),    32'h1);
        chk("t_idle",       32'(arb_busy),    32'h0);
        tick();
        tick();
        chk("t_sticky",     32'(timeout_err), 32'h1);
        do_reset();
        #1 chk("t_cleared", 32'(timeout_err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/max7219_cmd_arbiter.md
Name: max7219_cmd_arbiter

Overview:
- Shares one MAX7219 serial write engine (start/addr/data/busy interface) between NUM_REQ independent command sources, e.g. power-up init, digit refresh and brightness update.
- Each source posts single register writes (8-bit address, 8-bit data) through a valid/ready handshake.
- The arbiter grants round-robin, sequences the engine handshake and reports completion per source.
- Sits between the display-level sequencers and the serial engine; it is the only driver of the engine's start, address and data inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, clocks allowed per engine phase before abort (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*8  per-requester MAX7219 register address; slice i = bits [8i+7:8i].
- req_data  in  NUM_REQ*8  per-requester register data, same slicing.
- req_ready  out  NUM_REQ  one-hot; request i accepted this cycle.
- req_done  out  NUM_REQ  one-hot, 1-cycle pulse; write of requester i finished.
- eng_start  out  1  start request to the serial engine.
- eng_addr  out  8  address to the engine.
- eng_data  out  8  data to the engine.
- eng_busy  in  1  engine busy flag.
- arb_busy  out  1  high whenever state != IDLE.
- grant_id  out  3  index of the requester currently owning the engine; valid while arb_busy is high.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset values (all registered outputs): state IDLE, eng_start=0, eng_addr=0x00, eng_data=0x00, grant_id=0, timeout_err=0, req_done=0, last-grant pointer = NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-transaction: state returns to IDLE and eng_start drops on the next edge. The in-flight write is abandoned and no req_done is issued for it.
- IDLE, selection:
  - Acts only when eng_busy=0. If eng_busy is already high, no request is accepted.
  - Winner = first i with req_valid[i]=1, searching from (last+1) mod NUM_REQ upward with wrap.
- IDLE, acceptance:
  - req_ready[winner] is combinational, asserted in the same cycle as the selection. It is never asserted without the matching req_valid.
  - On that edge: capture addr/data into eng_addr/eng_data, grant_id=winner, last=winner, eng_start=1, state -> ISSUE.
- Requester rules:
  - Must hold valid/addr/data stable until it sees ready.
  - Dropping valid before ready is legal and withdraws the request; nothing is latched.
- ISSUE:
  - eng_start, eng_addr and eng_data are held constant.
  - When eng_busy=1: eng_start=0, state -> WAIT_DONE.
- WAIT_DONE:
  - When eng_busy=0: pulse req_done[grant_id] for 1 cycle, state -> IDLE.
  - eng_addr and eng_data keep their values until the next grant.
- Latency: accept edge to eng_start high = 1 cycle. Engine-done edge to req_done = 1 cycle. Minimum spacing between two accepts = engine time + 2 cycles.
- Simultaneous events:
  - A requester whose req_done fires may re-assert valid in the same cycle. It is arbitrated normally at its new round-robin position.
  - All requesters valid continuously: grant order 0,1,2,3,0,...
- No queueing: at most one outstanding write system-wide.

Optional Feature:
- Macro: MAX7219_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit phase counter clears on entry to ISSUE and on entry to WAIT_DONE, and increments every cycle in those states.
  - Counter reaching TIMEOUT_CYCLES-1 causes: eng_start=0, timeout_err=1 (sticky until reset), req_done[grant_id] pulses, state -> IDLE.
- Undefined: no counter; timeout_err is tied 0; the arbiter waits indefinitely on eng_busy.

Decomposition:
- Package max7219_pkg:
  - State enum {IDLE, ISSUE, WAIT_DONE}.
  - Register address constants: DIGIT0=0x01..DIGIT7=0x08, DECODE=0x09, INTENSITY=0x0A, SCAN_LIMIT=0x0B, SHUTDOWN=0x0C, TEST=0x0F.
  - ADDR_W=8, DATA_W=8.
- One natural sub-module: rr_picker, a combinational round-robin winner selector taking (valid vector, last index) and returning (found, index). Kept separate so it can be reused by the frame scheduler.

Test Plan:
- Single request: req_valid[2]=1, addr 0x0C, data 0x01, engine busy 20 cycles -> ready[2] same cycle; eng_start next cycle with eng_addr=0x0C, eng_data=0x01; start drops after busy rises; done[2] pulses 1 cycle after busy falls.
- Fairness: all four requesters valid continuously for 8 writes -> grant_id sequence 0,1,2,3,0,1,2,3; each requester gets exactly 2 done pulses.
- Engine already busy: eng_busy=1 at reset release, req_valid[0]=1 -> no ready until eng_busy=0, then ready[0] that cycle.
- Withdrawal: req_valid[1] pulsed 1 cycle while arbiter in WAIT_DONE -> no ready[1], no done[1], next grant goes to the next valid requester.
- Reset mid-transfer: reset asserted in WAIT_DONE -> next cycle state IDLE, eng_start=0, no done pulse; next request is granted starting from requester 0.
- (MAX7219_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) eng_busy never rises -> after 16 ISSUE cycles eng_start=0, timeout_err=1, done[grant_id] pulses; timeout_err stays 1 until reset.
